mem_stage_lsu: RTL and testbench

//  Memory stage of the 5-stage pipelined RV32I core; sits between the EX/MEM and MEM/WB boundaries.
//  - Consumes the EX/MEM register outputs.
//  - Performs byte/half/word loads and stores over a req/ack data-memory port.
//  - Stalls the front of the pipe while an access is outstanding.
//  - Contains the MEM/WB pipeline register that drives writeback.

---
 rtl/mem_stage_lsu_if.sv | 12 +
 rtl/mem_stage_lsu.sv | 88 ++++++++
 tb/tb_mem_stage_lsu.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: data-memory req/ack port between the MEM stage and data memory
interface mem_stage_lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    modport master(output mem_req, mem_we, mem_addr, mem_be, mem_wdata, input mem_rdata, mem_ack);
    modport slave(input mem_req, mem_we, mem_addr, mem_be, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RV32I memory stage with req/ack LSU, timeout abort and MEM/WB register
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   RegWriteM,
    input  logic                   MemWriteM,
    input  logic [1:0]             ResultSrcM,
    input  logic [2:0]             Funct3M,
    input  logic [31:0]            ALUResultM,
    input  logic [31:0]            WriteDataM,
    input  logic [4:0]             RdM,
    input  logic [31:0]            PCPlus4M,
    output logic                   StallM,
    mem_stage_lsu_if.master        mem,
    output logic                   RegWriteW,
    output logic [1:0]             ResultSrcW,
    output logic [31:0]            ALUResultW,
    output logic [31:0]            ReadDataW,
    output logic [4:0]             RdW,
    output logic [31:0]            PCPlus4W,
    output logic                   BusErrW,
    output logic                   MisalignW
);
    typedef enum logic {IDLE, REQ} state_t;
    state_t      state;
    logic [31:0] cnt;
    logic [1:0]  a;
    logic        access, misalign, trap, timeout, abort, done, take;
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] ld;
    assign a = ALUResultM[1:0];
    assign access = MemWriteM | (ResultSrcM == 2'b01);
`ifdef MISALIGN_TRAP_EN
    assign misalign = access & ((Funct3M[1:0] == 2'b01 & a[0]) | (Funct3M == 3'b010 & a != 2'b00));
`else
    assign misalign = 1'b0;
`endif
    assign trap = state == IDLE & misalign;
    assign timeout = TIMEOUT_CYCLES != 0 && cnt == 32'(TIMEOUT_CYCLES - 1);
    assign abort = state == REQ & ~mem.mem_ack & timeout;
    assign done = state == REQ & (mem.mem_ack | timeout);
    assign take = state == IDLE ? ~access | trap : done;
    // Gated by rst so the upstream stall releases together with the async reset
    assign StallM = ~rst & (state == IDLE ? access & ~trap : ~mem.mem_ack & ~timeout);
    assign mem.mem_req = state == REQ;
    assign mem.mem_we = MemWriteM;
    assign mem.mem_addr = {ALUResultM[31:2], 2'b00};
    assign mem.mem_be = ~MemWriteM ? 4'b1111 :
                        Funct3M == 3'b000 ? 4'b0001 << a :
                        Funct3M == 3'b001 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign mem.mem_wdata = Funct3M == 3'b000 ? {4{WriteDataM[7:0]}} :
                           Funct3M == 3'b001 ? {2{WriteDataM[15:0]}} : WriteDataM;
    assign lb = mem.mem_rdata[{a, 3'b000} +: 8];
    assign lh = a[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    always_comb
        ld = Funct3M == 3'b000 ? {{24{lb[7]}}, lb} :
             Funct3M == 3'b001 ? {{16{lh[15]}}, lh} :
             Funct3M == 3'b100 ? {24'd0, lb} :
             Funct3M == 3'b101 ? {16'd0, lh} : mem.mem_rdata;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
            PCPlus4W   <= '0;
            BusErrW    <= 1'b0;
            MisalignW  <= 1'b0;
        end else begin
            state      <= state == IDLE ? (access & ~trap ? REQ : IDLE) : (done ? IDLE : REQ);
            cnt        <= state == IDLE ? '0 : cnt + 32'd1;
            RegWriteW  <= take & RegWriteM & ~trap & ~abort;
            ResultSrcW <= take ? ResultSrcM : '0;
            ALUResultW <= take ? ALUResultM : '0;
            ReadDataW  <= state == REQ & mem.mem_ack & ~MemWriteM ? ld : '0;
            RdW        <= take ? RdM : '0;
            PCPlus4W   <= take ? PCPlus4M : '0;
            BusErrW    <= abort;
            MisalignW  <= trap;
        end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: randomized transaction-level check of mem_stage_lsu against a spec model
module tb_mem_stage_lsu;
    localparam int TO = 4;
    logic        clk, rst;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        StallM;
    logic        RegWriteW, BusErrW, MisalignW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW;
    int checks = 0, errors = 0;
    mem_stage_lsu_if bus();
    mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
        .StallM(StallM), .mem(bus),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
        .RdW(RdW), .PCPlus4W(PCPlus4W), .BusErrW(BusErrW), .MisalignW(MisalignW)
    );
    initial clk = 0;
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_w(input logic rw, input logic [1:0] rs, input logic [31:0] alu, input logic [31:0] rdd,
                           input logic [4:0] rd, input logic [31:0] pc4, input logic be, input logic mi);
        check("RegWriteW", RegWriteW, rw);
        check("ResultSrcW", ResultSrcW, rs);
        check("ALUResultW", ALUResultW, alu);
        check("ReadDataW", ReadDataW, rdd);
        check("RdW", RdW, rd);
        check("PCPlus4W", PCPlus4W, pc4);
        check("BusErrW", BusErrW, be);
        check("MisalignW", MisalignW, mi);
    endtask

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input int a, input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * a)) & 255;
        h = (w >> (16 * (a / 2))) & 65535;
        case (f3)
            3'b000: return b > 127 ? b - 256 : b;
            3'b001: return h > 32767 ? h - 65536 : h;
            3'b100: return b;
            3'b101: return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] exp_be(input logic mw, input logic [2:0] f3, input int a);
        if (!mw) return 4'hF;
        if (f3 == 3'b000) return 4'(1 << a);
        if (f3 == 3'b001) return a >= 2 ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 3'b000) return (wd & 255) * 32'h0101_0101;
        if (f3 == 3'b001) return (wd & 65535) * 32'h0001_0001;
        return wd;
    endfunction

    task automatic drive(input logic rw, input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] pc4);
        RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; Funct3M = f3;
        ALUResultM = alu; WriteDataM = wd; RdM = rd; PCPlus4M = pc4;
    endtask

    // One instruction through MEM: lat = REQ cycle index that acks (>= TO means never)
    task automatic run_op(input logic rw, input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] pc4, input int lat, input logic [31:0] rdat);
        bit acc, mis, fin;
        int a;
        drive(rw, mw, rs, f3, alu, wd, rd, pc4);
        a = alu % 4;
        acc = mw || rs == 2'b01;
        mis = 0;
`ifdef MISALIGN_TRAP_EN
        mis = acc && ((f3 % 4 == 1 && a % 2 == 1) || (f3 == 3'b010 && a != 0));
`endif
        bus.mem_ack = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        #1;
        check("StallM_idle", StallM, acc && !mis);
        check("mem_req_idle", bus.mem_req, 0);
        @(posedge clk); @(negedge clk);
        bus.mem_ack = 0;
        if (!acc || mis) begin
            check_w(rw && !mis, rs, alu, 0, rd, pc4, 0, mis);
            return;
        end
        check_w(0, 0, 0, 0, 0, 0, 0, 0);
        fin = 0;
        for (int k = 0; k < 8 && !fin; k++) begin
            check("mem_req", bus.mem_req, 1);
            check("mem_we", bus.mem_we, mw);
            check("mem_addr", bus.mem_addr, alu - a);
            check("mem_be", bus.mem_be, exp_be(mw, f3, a));
            if (mw) check("mem_wdata", bus.mem_wdata, exp_wd(f3, wd));
            bus.mem_ack = k == lat;
            bus.mem_rdata = rdat;
            #1;
            fin = k == lat || k == TO - 1;
            check("StallM_req", StallM, !fin);
            @(posedge clk); @(negedge clk);
            bus.mem_ack = 0;
            if (fin && k == lat) check_w(rw, rs, alu, mw ? 0 : exp_load(f3, a, rdat), rd, pc4, 0, 0);
            else if (fin) check_w(0, rs, alu, 0, rd, pc4, 1, 0);
            else check_w(0, 0, 0, 0, 0, 0, 0, 0);
        end
        check("completed", fin, 1);
    endtask

    initial begin
        logic [1:0] rs;
        logic mw;
        int t;
        rst = 1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        bus.mem_ack = 0;
        bus.mem_rdata = 0;
        @(negedge clk);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_StallM", StallM, 0);
        check_w(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 0;
        run_op(1, 0, 2'b00, 3'b000, 32'h10, 0, 5, 32'h104, 0, 0);
        #2 rst = 1;
        #1;
        check("async_rst_RdW", RdW, 0);
        check("async_rst_ALUResultW", ALUResultW, 0);
        check("async_rst_RegWriteW", RegWriteW, 0);
        @(negedge clk) rst = 0;
        drive(1, 0, 2'b01, 3'b010, 32'h40, 0, 9, 32'h200);
        @(posedge clk); @(negedge clk);
        check("pre_rst_mem_req", bus.mem_req, 1);
        #2 rst = 1;
        #1;
        check("mid_req_rst_mem_req", bus.mem_req, 0);
        check("mid_req_rst_StallM", StallM, 0);
        check_w(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk) rst = 0;
        run_op(1, 0, 2'b10, 3'b000, 32'h77, 0, 3, 32'h300, 0, 0);
        run_op(1, 0, 2'b01, 3'b000, 32'h103, 0, 7, 32'h404, 0, 32'h80FF_FF00);
        run_op(0, 1, 2'b00, 3'b001, 32'h202, 32'h1234_ABCD, 0, 32'h408, 3, 0);
        run_op(1, 0, 2'b01, 3'b010, 32'h500, 0, 8, 32'h40C, 99, 32'hDEAD_BEEF);
        run_op(1, 0, 2'b01, 3'b010, 32'h6, 0, 10, 32'h410, 1, 32'hCAFE_F00D);
        for (int i = 0; i < 80; i++) begin
            t = $urandom_range(0, 3);
            mw = t >= 2;
            rs = t[0] ? 2'b01 : {1'($urandom_range(0, 1)), 1'b0};
            run_op(1'($urandom_range(0, 1)), mw, rs, 3'($urandom), $urandom, $urandom, 5'($urandom),
                   $urandom, $urandom_range(0, 5), $urandom);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
